// File: rtl/axi4l_initiator.sv
// AXI4-lite single-outstanding initiator: converts write/read request pulses into AW/W/B or AR/R transactions.
// Optional response timeout is enabled by defining AXI4L_INITIATOR_TIMEOUT_EN.
module axi4l_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  wr_req_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [31:0]           wdata_o,
    output logic [3:0]            wstrb_o,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    input  logic [1:0]            bresp_i,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic                  awvalid_r, awvalid_s;
    logic                  wvalid_r, wvalid_s;
    logic                  bready_r, bready_s;
    logic                  arvalid_r, arvalid_s;
    logic                  rready_r, rready_s;
    logic                  ack_r, ack_s;
    logic                  err_r, err_s;
    logic [31:0]           rdata_r, rdata_s;
    logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_s;
    logic [31:0]           wdata_r, wdata_s;
    logic [3:0]            wstrb_r, wstrb_s;
    logic [ADDR_WIDTH-1:0] araddr_r, araddr_s;

`ifdef AXI4L_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             unused_s;
    assign unused_s = ^{bresp_i[0], rresp_i[0]};
`else
    logic unused_s;
    assign unused_s = ^{bresp_i[0], rresp_i[0], TIMEOUT[0]};
`endif

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_s   = state_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        bready_s  = bready_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
        ack_s     = 1'b0;
        err_s     = 1'b0;
        rdata_s   = rdata_r;
        awaddr_s  = awaddr_r;
        wdata_s   = wdata_r;
        wstrb_s   = wstrb_r;
        araddr_s  = araddr_r;
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
        cnt_s     = '0;
`endif
        case (state_r)
            ST_IDLE: begin
                // Write wins over a coincident read; the read is simply dropped.
                if (wr_req_i) begin
                    state_s   = ST_WRITE;
                    awvalid_s = 1'b1;
                    wvalid_s  = 1'b1;
                    awaddr_s  = addr_i;
                    wdata_s   = wdata_i;
                    wstrb_s   = wstrb_i;
                end else if (rd_req_i) begin
                    state_s   = ST_READ;
                    arvalid_s = 1'b1;
                    araddr_s  = addr_i;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (awvalid_r && awready_i) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (wvalid_r && wready_i) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if (bready_r && bvalid_i) begin
                    bready_s = 1'b0;
                    ack_s    = 1'b1;
                    err_s    = bresp_i[1];
                    state_s  = ST_IDLE;
                end else begin
                    bready_s = !awvalid_s && !wvalid_s;
                end
            end
            ST_READ: begin
                if (arvalid_r && arready_i) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                end else begin
                    arvalid_s = arvalid_r;
                end
                if (rready_r && rvalid_i) begin
                    rready_s = 1'b0;
                    rdata_s  = rdata_i;
                    ack_s    = 1'b1;
                    err_s    = rresp_i[1];
                    state_s  = ST_IDLE;
                end else begin
                    state_s  = ST_READ;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
            end
        endcase
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
        // A real completion in the final cycle takes precedence over the timeout.
        if (state_r != ST_IDLE) begin
            if (ack_s) begin
                cnt_s = '0;
            end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                ack_s     = 1'b1;
                err_s     = 1'b1;
                state_s   = ST_IDLE;
                cnt_s     = '0;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = '0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_r   <= ST_IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 32'h0;
            awaddr_r  <= '0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
            araddr_r  <= '0;
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
            cnt_r     <= '0;
`endif
        end else begin
            state_r   <= state_s;
            awvalid_r <= awvalid_s;
            wvalid_r  <= wvalid_s;
            bready_r  <= bready_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            ack_r     <= ack_s;
            err_r     <= err_s;
            rdata_r   <= rdata_s;
            awaddr_r  <= awaddr_s;
            wdata_r   <= wdata_s;
            wstrb_r   <= wstrb_s;
            araddr_r  <= araddr_s;
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
            cnt_r     <= cnt_s;
`endif
        end
    end

    assign ack_o     = ack_r;
    assign err_o     = err_r;
    assign rdata_o   = rdata_r;
    assign awvalid_o = awvalid_r;
    assign awaddr_o  = awaddr_r;
    assign wvalid_o  = wvalid_r;
    assign wdata_o   = wdata_r;
    assign wstrb_o   = wstrb_r;
    assign bready_o  = bready_r;
    assign arvalid_o = arvalid_r;
    assign araddr_o  = araddr_r;
    assign rready_o  = rready_r;

endmodule

// File: doc/axi4l_initiator.md
AXI4L_INITIATOR -- requirements
Module: axi4l_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-lite address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, response timeout in aclk cycles (used only with REQ-044).
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_req_i  input  1  single-cycle write request pulse.
REQ-006 SHALL have port rd_req_i  input  1  single-cycle read request pulse.
REQ-007 SHALL have port addr_i  input  ADDR_WIDTH  request byte address.
REQ-008 SHALL have port wdata_i  input  32  write data.
REQ-009 SHALL have port wstrb_i  input  4  write byte strobes.
REQ-010 SHALL have port ack_o  output  1  single-cycle completion pulse.
REQ-011 SHALL have port err_o  output  1  error flag, valid only with ack_o.
REQ-012 SHALL have port rdata_o  output  32  read data, valid from read ack_o.
REQ-013 SHALL have port awvalid_o  output  1  AW valid.
REQ-014 SHALL have port awready_i  input  1  AW ready.
REQ-015 SHALL have port awaddr_o  output  ADDR_WIDTH  write address.
REQ-016 SHALL have port wvalid_o  output  1  W valid.
REQ-017 SHALL have port wready_i  input  1  W ready.
REQ-018 SHALL have port wdata_o  output  32  write data.
REQ-019 SHALL have port wstrb_o  output  4  write strobes.
REQ-020 SHALL have port bvalid_i  input  1  B valid.
REQ-021 SHALL have port bready_o  output  1  B ready.
REQ-022 SHALL have port bresp_i  input  2  write response.
REQ-023 SHALL have port arvalid_o  output  1  AR valid.
REQ-024 SHALL have port arready_i  input  1  AR ready.
REQ-025 SHALL have port araddr_o  output  ADDR_WIDTH  read address.
REQ-026 SHALL have port rvalid_i  input  1  R valid.
REQ-027 SHALL have port rready_o  output  1  R ready.
REQ-028 SHALL have port rdata_i  input  32  read data.
REQ-029 SHALL have port rresp_i  input  2  read response; no prot ports, the integrator ties AxPROT to 3'b000.

Function
REQ-030 SHALL implement FSM IDLE/WRITE/READ; requests SHALL be accepted only in IDLE, and pulses in any other state are ignored.
REQ-031 SHALL give wr_req_i priority when wr_req_i and rd_req_i coincide in IDLE; the read is dropped with no ack.
REQ-032 SHALL, on an accepted write at cycle T, register addr/data/strb and assert awvalid_o and wvalid_o from T+1, entering WRITE.
REQ-033 SHALL deassert awvalid_o and wvalid_o independently, each the cycle after its own valid&ready handshake; payload stays stable while valid.
REQ-034 SHALL hold bready_o high only in WRITE once both AW and W handshakes are done; bvalid_i at any other time is ignored.
REQ-035 SHALL, on an accepted read at T, register the address and assert arvalid_o from T+1, dropping it the cycle after arvalid_o&arready_i.
REQ-036 SHALL hold rready_o high only in READ after the AR handshake; on rvalid_i&rready_o it captures rdata_i into rdata_o.
REQ-037 SHALL pulse ack_o for exactly one cycle the cycle after the B/R handshake, with err_o=bresp_i[1]/rresp_i[1], returning to IDLE in that same cycle.
REQ-038 SHALL give a minimum latency of request at T, ack_o at T+3, with a new request accepted at T+3.
REQ-039 SHALL keep err_o low whenever ack_o is low, and keep rdata_o unchanged until the next read completion.

Reset
REQ-040 SHALL, while areset_n=0, force FSM=IDLE and all outputs to 0, including rdata_o; reset mid-transaction abandons it with no ack_o.

Configuration
REQ-044 SHALL, with macro AXI4L_INITIATOR_TIMEOUT_EN defined, count cycles in WRITE/READ; at TIMEOUT cycles without completion it drops all valid/ready, pulses ack_o with err_o=1 and returns to IDLE.
REQ-045 SHALL, without AXI4L_INITIATOR_TIMEOUT_EN, contain no counter, wait indefinitely and ignore TIMEOUT.

Verification
REQ-050 Write 0x8/0xCAFEF00D/strb 0xF with awready, wready and bvalid immediate, bresp=00 -> ack_o at T+3, err_o=0, awaddr_o=0x8.
REQ-051 Read 0x4, arready at T+3, rvalid at T+5 with rdata 0x12345678, rresp=10 -> ack_o at T+6, err_o=1, rdata_o=0x12345678.
REQ-052 Write with wready at T+1 and awready at T+4 -> wvalid_o low from T+2, bready_o high from T+5, single ack.
REQ-053 wr_req_i and rd_req_i in the same cycle, then rd_req_i while busy -> write only, arvalid_o never asserted.
REQ-054 areset_n low during WRITE with awvalid_o high -> outputs 0 immediately, no ack_o; with TIMEOUT_EN and TIMEOUT=16 and no bvalid -> ack_o with err_o=1 after 16 cycles.
